// File: rtl/jtag_bitbang_driver.sv
// JTAG bit-bang driver: shifts TMS/TDI vectors out on a divided TCK
// and captures TDO on each rising TCK edge, with optional TRST pulse.
module jtag_bitbang_driver #(
   parameter int TCK_PERIOD  = 10,
   parameter int MAX_LEN     = 32,
   parameter int TRST_CYCLES = 8,
   localparam int LW = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [LW-1:0]      cmd_len,
   input  logic [MAX_LEN-1:0] cmd_tms,
   input  logic [MAX_LEN-1:0] cmd_tdi,
   input  logic               cmd_trst,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_tdo,
   output logic               busy,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   output logic               trstn,
   input  logic               tdo
);

   localparam int H    = TCK_PERIOD / 2;
   localparam int CMAX = (H > TRST_CYCLES) ? H : TRST_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] H_LAST = CW'(H - 1);
   localparam logic [CW-1:0] T_LAST = CW'(TRST_CYCLES - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TRST = 3'd1;
   localparam logic [2:0] S_LO   = 3'd2;
   localparam logic [2:0] S_HI   = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]         state;
   logic [CW-1:0]      cnt;
   logic [LW-1:0]      rem;
   logic [LW-1:0]      len_eff;
   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] tms_sh;
   logic [MAX_LEN-1:0] tdi_sh;

   assign len_eff = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
   assign cmd_ready = (state == S_IDLE) && !rst;
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rem       <= '0;
         mask      <= '0;
         tms_sh    <= '0;
         tdi_sh    <= '0;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         trstn     <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_tdo   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  rem     <= len_eff;
                  mask    <= MAX_LEN'(1);
                  cnt     <= '0;
                  rsp_tdo <= '0;
                  tms_sh  <= cmd_tms;
                  tdi_sh  <= cmd_tdi;
                  if (cmd_trst) begin
                     state <= S_TRST;
                     trstn <= 1'b0;
                     tms   <= 1'b1;
                  end else if (len_eff != '0) begin
                     state  <= S_LO;
                     tms    <= cmd_tms[0];
                     tdi    <= cmd_tdi[0];
                     tms_sh <= cmd_tms >> 1;
                     tdi_sh <= cmd_tdi >> 1;
                  end else begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            S_TRST: begin
               if (cnt == T_LAST) begin
                  cnt   <= '0;
                  trstn <= 1'b1;
                  if (rem != '0) begin
                     state  <= S_LO;
                     tms    <= tms_sh[0];
                     tdi    <= tdi_sh[0];
                     tms_sh <= tms_sh >> 1;
                     tdi_sh <= tdi_sh >> 1;
                  end else begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_LO: begin
               if (cnt == H_LAST) begin
                  cnt     <= '0;
                  state   <= S_HI;
                  tck     <= 1'b1;
                  rsp_tdo <= rsp_tdo | (tdo ? mask : '0);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_HI: begin
               if (cnt == H_LAST) begin
                  cnt <= '0;
                  tck <= 1'b0;
                  if (rem == LW'(1)) begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state  <= S_LO;
                     rem    <= rem - LW'(1);
                     mask   <= mask << 1;
                     tms    <= tms_sh[0];
                     tdi    <= tdi_sh[0];
                     tms_sh <= tms_sh >> 1;
                     tdi_sh <= tdi_sh >> 1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_bitbang_driver.sv
// Randomized bench for jtag_bitbang_driver against a cycle-timing
// model derived from the TCK period arithmetic.
module tb_jtag_bitbang_driver;

   localparam int P  = 4;
   localparam int H  = P / 2;
   localparam int ML = 8;
   localparam int TR = 3;
   localparam int LW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len = '0;
   logic [ML-1:0] cmd_tms = '0;
   logic [ML-1:0] cmd_tdi = '0;
   logic          cmd_trst = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [ML-1:0] rsp_tdo;
   logic          busy;
   logic          tck;
   logic          tms;
   logic          tdi;
   logic          trstn;
   logic          tdo;
   logic          tdo_r = 1'b0;
   logic          lb = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   logic last_tms = 1'b1;
   logic last_tdi = 1'b0;

   assign tdo = lb ? tdi : tdo_r;

   always #5 clk = ~clk;

   jtag_bitbang_driver #(
      .TCK_PERIOD (P),
      .MAX_LEN    (ML),
      .TRST_CYCLES(TR)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_len  (cmd_len),
      .cmd_tms  (cmd_tms),
      .cmd_tdi  (cmd_tdi),
      .cmd_trst (cmd_trst),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_tdo  (rsp_tdo),
      .busy     (busy),
      .tck      (tck),
      .tms      (tms),
      .tdi      (tdi),
      .trstn    (trstn),
      .tdo      (tdo)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_tck", tck, 0);
      chk("rst_tms", tms, 1);
      chk("rst_tdi", tdi, 0);
      chk("rst_trstn", trstn, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_tdo", rsp_tdo, 0);
      chk("rst_busy", busy, 0);
   endtask

   // mode: 0 random tdo, 1 loopback tdo=tdi, 2 tdo tied high
   task automatic run_cmd(input int len, input logic [7:0] tm,
                          input logic [7:0] ti, input logic trs,
                          input int mode, input int hold,
                          input logic noise);
      int L, D, tot, m;
      logic e_tck, e_tms, e_tdi, e_trstn;
      logic [7:0] e_tdo;
      logic tdo_at [0:63];
      L   = (len > ML) ? ML : len;
      D   = trs ? TR : 0;
      tot = D + L * P;
      e_tdo = '0;
      for (int i = 0; i < 64; i++) tdo_at[i] = 1'b0;
      lb       = (mode == 1);
      cmd_len  = LW'(len);
      cmd_tms  = tm;
      cmd_tdi  = ti;
      cmd_trst = trs;
      cmd_valid = 1'b1;
      chk("cmd_ready_idle", cmd_ready, 1);
      tdo_r = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      for (int n = 0; n <= tot; n++) begin
         m = n - D;
         if (n < D) begin
            e_tck = 0; e_trstn = 0; e_tms = 1; e_tdi = last_tdi;
         end else if (m < L * P) begin
            e_tck = ((m % P) >= H); e_trstn = 1;
            e_tms = tm[m / P]; e_tdi = ti[m / P];
         end else begin
            e_tck = 0; e_trstn = 1;
            e_tms = (L > 0) ? tm[L-1] : (trs ? 1'b1 : last_tms);
            e_tdi = (L > 0) ? ti[L-1] : last_tdi;
         end
         chk("tck", tck, e_tck);
         chk("trstn", trstn, e_trstn);
         chk("tms", tms, e_tms);
         chk("tdi", tdi, e_tdi);
         chk("rsp_valid", rsp_valid, (n >= tot));
         chk("busy", busy, 1);
         chk("cmd_ready_busy", cmd_ready, 0);
         if (n == tot) begin
            for (int k = 0; k < L; k++)
               e_tdo[k] = (mode == 1) ? ti[k] : tdo_at[D + H + k * P];
            chk("rsp_tdo", rsp_tdo, e_tdo);
         end else begin
            tdo_r = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            tdo_at[n + 1] = lb ? 1'b0 : tdo_r;
            if (noise) begin
               cmd_valid = 1'($urandom_range(0, 1));
               cmd_len   = LW'($urandom_range(0, 15));
               cmd_tms   = 8'($urandom);
               cmd_tdi   = 8'($urandom);
               cmd_trst  = 1'($urandom_range(0, 1));
            end else begin
               cmd_valid = 1'b0;
            end
            tick();
         end
      end
      for (int w = 0; w < hold; w++) begin
         tdo_r = 1'($urandom_range(0, 1));
         tick();
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_tdo", rsp_tdo, e_tdo);
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_tck", tck, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      last_tms = e_tms;
      last_tdi = e_tdi;
      chk("done_rsp_valid", rsp_valid, 0);
      chk("done_busy", busy, 0);
      chk("done_cmd_ready", cmd_ready, 1);
      chk("done_tms", tms, last_tms);
      chk("done_tdi", tdi, last_tdi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      tick();
      tick();
      chk_reset_vals();
      chk("cmd_ready_in_rst", cmd_ready, 0);
      rst = 1'b0;
      #1;
      chk("cmd_ready_after_rst", cmd_ready, 1);

      run_cmd(5, 8'b00110, 8'b10101, 1'b0, 2, 0, 1'b0);
      run_cmd(8, 8'h3C, 8'hA5, 1'b0, 1, 1, 1'b0);
      run_cmd(12, 8'h96, 8'hA5, 1'b0, 1, 0, 1'b0);
      run_cmd(0, 8'h00, 8'h00, 1'b1, 0, 0, 1'b0);
      run_cmd(0, 8'h00, 8'h00, 1'b0, 0, 2, 1'b0);
      run_cmd(3, 8'h05, 8'h06, 1'b0, 0, 10, 1'b1);
      run_cmd(4, 8'h09, 8'h0C, 1'b1, 0, 1, 1'b0);

      // abort during the third TCK high phase of an 8-bit shift
      cmd_len  = LW'(8);
      cmd_tms  = 8'hFF;
      cmd_tdi  = 8'hFF;
      cmd_trst = 1'b0;
      cmd_valid = 1'b1;
      lb = 1'b0;
      tdo_r = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (2 * P + H) tick();
      chk("abort_in_hi", tck, 1);
      rst = 1'b1;
      tick();
      chk_reset_vals();
      rst = 1'b0;
      last_tms = 1'b1;
      last_tdi = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("abort_no_rsp", rsp_valid, 0);
         chk("abort_idle", busy, 0);
      end

      for (int r = 0; r < 40; r++) begin
         run_cmd($urandom_range(0, 12), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
